demux_rr_sched: RTL

//  Round-robin scheduler sequencing a 1xN demultiplexer: accepts a single input stream
//  (valid/ready), holds one word, drives demux select/enable so each word reaches exactly one
//  of N destinations. Destinations are visited in rotating order, skipping masked-off ones.

---
 rtl/demux_rr_sched_pkg.sv | 8 +
 rtl/demux_rr_sched_rr_pick.sv | 35 +++
 rtl/demux_rr_sched.sv | 94 +++++++++
 3 files changed

// File: rtl/demux_rr_sched_pkg.sv
// Shared types for the round-robin demux scheduler.
// State encoding is fixed (IDLE=0, SEND=1) so benches and debug tools can decode it.
package demux_rr_sched_pkg;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;
endpackage

// File: rtl/demux_rr_sched_rr_pick.sv
// Combinational round-robin search: first set mask bit at or after i_start, wrapping at N.
// Works for any N in 2..64, including non-power-of-two N.
import demux_rr_sched_pkg::*;

module rr_pick #(
    parameter  int N = 8,
    localparam int M = $clog2(N)
) (
    input  logic [N-1:0] i_mask,
    input  logic [M-1:0] i_start,
    output logic [M-1:0] o_idx,
    output logic         o_found
);

    // i_start is always < N, so a single subtract is enough to wrap.
    function automatic logic [M-1:0] wrap_add(input logic [M-1:0] a, input int k);
        int s;
        s = int'(a) + k;
        if (s >= N) s = s - N;
        return s[M-1:0];
    endfunction

    // Scan from the far end so the nearest hit to i_start is written last.
    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_mask[wrap_add(i_start, k)]) begin
                o_idx   = wrap_add(i_start, k);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_rr_sched.sv
// Round-robin scheduler for a 1xN demux: holds one word, drives sel/out_en/out_valid,
// and rotates across destinations enabled in i_dest_mask. Sustains one word per clock.
import demux_rr_sched_pkg::*;

module demux_rr_sched #(
    parameter  int N = 8,
    parameter  int W = 1,
    localparam int M = $clog2(N)
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    input  logic [W-1:0] i_in_data,
    output logic         o_in_ready,
    input  logic [N-1:0] i_dest_mask,
    input  logic [N-1:0] i_out_ready,
    output logic [M-1:0] o_sel,
    output logic         o_out_en,
    output logic [W-1:0] o_out_data,
    output logic [N-1:0] o_out_valid
);

    state_t       r_state;
    logic [M-1:0] r_ptr;
    logic [M-1:0] r_sel;
    logic         r_en;
    logic [W-1:0] r_data;

    logic [M-1:0] w_sel_nxt;
    logic [M-1:0] w_start;
    logic [M-1:0] w_pick;
    logic         w_found;
    logic         w_xfer;
    logic         w_acc;

    assign w_sel_nxt = (r_sel == M'(N - 1)) ? '0 : r_sel + 1'b1;
    // In SEND a new word is only accepted alongside a transfer, so the search starts past sel.
    assign w_start   = (r_state == ST_SEND) ? w_sel_nxt : r_ptr;

    rr_pick #(.N(N)) u_pick (
        .i_mask  (i_dest_mask),
        .i_start (w_start),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    assign w_xfer     = (r_state == ST_SEND) && i_out_ready[r_sel];
    assign o_in_ready = !i_rst && w_found && ((r_state == ST_IDLE) || i_out_ready[r_sel]);
    assign w_acc      = i_in_valid && o_in_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_en    <= 1'b0;
            r_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        r_data  <= i_in_data;
                        r_sel   <= w_pick;
                        r_en    <= 1'b1;
                        r_state <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_xfer) begin
                        r_ptr <= w_sel_nxt;
                        if (w_acc) begin
                            r_data <= i_in_data;
                            r_sel  <= w_pick;
                        end else begin
                            r_en    <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_sel      = r_sel;
    assign o_out_en   = r_en;
    assign o_out_data = r_data;

    always_comb begin
        o_out_valid = '0;
        if (r_en) o_out_valid[r_sel] = 1'b1;
    end

endmodule
